// File: rtl/hamm74_pkg.sv
// rtl/hamm74_pkg.sv - shared widths, FSM encoding and Hamming(7,4) encoder for the serial transmitter
package hamm74_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam logic [2:0] NO_ERR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Code layout matches the link decoder: data in c[6:3], parity in c[2:0].
  function automatic logic [CODE_W-1:0] hamm74_enc(input logic [DATA_W-1:0] d);
    logic p2, p1, p0;
    p2 = d[3] ^ d[2] ^ d[1];
    p1 = d[3] ^ d[2] ^ d[0];
    p0 = d[3] ^ d[1] ^ d[0];
    return {d, p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamm74_fifo.sv
// rtl/hamm74_fifo.sv - synchronous word FIFO with registered full/empty flags
module hamm74_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       cnt_q;
  logic [AW:0]       cnt_d;
  logic              full_q;
  logic              empty_q;
  logic              push_ok;
  logic              pop_ok;

  // Flags gate the strobes so an over-push or under-pop can never corrupt the pointers.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign rdata   = mem[rd_q];

  // Occupancy after this cycle's push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy and flags; reset flushes all pending words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/hamm74_ser_tx.sv
// rtl/hamm74_ser_tx.sv - Hamming(7,4) encoder and MSB-first serialiser; optional HAMM74_ERR_INJECT_EN
module hamm74_ser_tx
  import hamm74_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_frame,
  output logic              tx_sof,
  output logic [CODE_W-1:0] code_par,
  input  logic [2:0]        inj_pos,
  input  logic              inj_req
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [CODE_W-1:0] code_ld;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-2:0] shreg_q;
  logic [2:0]        bit_q;
  logic [CW-1:0]     cyc_q;
  logic              tx_bit_q;
  logic              frame_q;
  logic              sof_q;
  logic              last_cyc;
  logic              last_bit;

  // Ready is forced low while reset is held so no word is taken during reset.
  assign din_ready = !fifo_full && !rst;
  assign push      = din_valid && din_ready;

  assign last_cyc  = (cyc_q == CYC_LAST);
  assign last_bit  = (bit_q == 3'd0);

  assign tx_bit    = tx_bit_q;
  assign tx_frame  = frame_q;
  assign tx_sof    = sof_q;
  assign code_par  = code_q;

  hamm74_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (din),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HAMM74_ERR_INJECT_EN
  logic       inj_armed_q;
  logic [2:0] inj_pos_q;
  logic [7:0] inj_onehot;

  // One-shot arm: a request latches the position, the next LOAD consumes it.
  // A request coinciding with a LOAD re-arms for the frame after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_armed_q <= 1'b0;
      inj_pos_q   <= NO_ERR;
    end else if (inj_req) begin
      inj_armed_q <= 1'b1;
      inj_pos_q   <= inj_pos;
    end else if (pop) begin
      inj_armed_q <= 1'b0;
    end
  end

  // Position 7 lands outside the code and so flips nothing.
  always_comb begin
    inj_onehot = 8'd1 << inj_pos_q;
    flip_mask  = '0;
    if (inj_armed_q && (inj_pos_q != NO_ERR)) flip_mask = inj_onehot[CODE_W-1:0];
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_pos, inj_req};
  assign flip_mask  = '0;
`endif

  assign code_ld = hamm74_enc(head) ^ flip_mask;

  // Frame sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pop strobe; LOAD always pops exactly one word.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop     = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_cyc && last_bit) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered serial datapath: load the code, then hold each bit BIT_CYCLES cycles MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q   <= '0;
      shreg_q  <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      tx_bit_q <= 1'b0;
      frame_q  <= 1'b0;
      sof_q    <= 1'b0;
    end else begin
      sof_q <= 1'b0;
      if (state_q == ST_LOAD) begin
        code_q   <= code_ld;
        shreg_q  <= code_ld[CODE_W-2:0];
        tx_bit_q <= code_ld[CODE_W-1];
        bit_q    <= 3'd6;
        cyc_q    <= '0;
        frame_q  <= 1'b1;
        sof_q    <= 1'b1;
      end else if (state_q == ST_SHIFT) begin
        if (last_cyc) begin
          cyc_q <= '0;
          if (last_bit) begin
            frame_q  <= 1'b0;
            tx_bit_q <= 1'b0;
          end else begin
            bit_q    <= bit_q - 3'd1;
            tx_bit_q <= shreg_q[CODE_W-2];
            shreg_q  <= {shreg_q[CODE_W-3:0], 1'b0};
          end
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
      end
    end
  end

endmodule
